// File: rtl/vga_timing_gen_if.sv
// Pixel request / return bus between the VGA timing generator and the
// upstream frame or image logic. The timing side (master) issues a
// position and the upstream side (slave) answers with RGB a fixed number
// of cycles later; there is no backpressure in either direction.
interface vga_timing_gen_if;

    // Request channel, timing generator -> upstream
    logic       req;          // high for active-area positions only
    logic [9:0] req_x;        // requested column, 0 outside the active area
    logic [9:0] req_y;        // requested row, 0 outside the active area
    logic       frame_start;  // pulses with the request for (0,0)
    logic       line_start;   // pulses with every request where x = 0

    // Return channel, upstream -> timing generator
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;

    modport master (
        output req,
        output req_x,
        output req_y,
        output frame_start,
        output line_start,
        input  r,
        input  g,
        input  b
    );

    modport slave (
        input  req,
        input  req_x,
        input  req_y,
        input  frame_start,
        input  line_start,
        output r,
        output g,
        output b
    );

endinterface

// File: rtl/vga_timing_gen.sv
// VGA pixel timing and output stage. Free-running horizontal/vertical
// counters produce a pixel request one cycle later, and a short delay
// line carries sync/active alongside so that the RGB returned by upstream
// DATA_LAT cycles after the request meets its own syncs at the pins.
//
// Pipeline for the counter value (h,v) held in cycle t:
//   t               counters, combinational decode of active/syncs
//   t+1             request stage (req, x, y, frame/line start), dly_q[0]
//   t+1+DATA_LAT    dly_q[DATA_LAT]; upstream data present on pix_if.r/g/b
//   t+2+DATA_LAT    output register drives the VGA pins
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned DATA_LAT = 1   // upstream read latency, 1..4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,

    vga_timing_gen_if.master        pix_if,

    output logic [7:0]              o_vga_r,
    output logic [7:0]              o_vga_g,
    output logic [7:0]              o_vga_b,
    output logic                    o_h_sync,
    output logic                    o_v_sync,
    output logic                    o_blank_n
);

    // ------------------------------------------------------------------
    // Timing constants, pre-sized to the 10-bit counter width
    // ------------------------------------------------------------------
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    // Control bits that travel with a pixel position down the pipeline.
    // Syncs are kept in their active-low pin polarity throughout.
    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic act;
    } vid_ctl_t;

    // Blanked, no-sync state used for reset and for every idle stage
    localparam vid_ctl_t CTL_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, act: 1'b0};

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       h_wrap;

    vid_ctl_t   cur_ctl;

    logic       req_q, req_d;
    logic [9:0] req_x_q, req_x_d;
    logic [9:0] req_y_q, req_y_d;
    logic       frame_start_q, frame_start_d;
    logic       line_start_q, line_start_d;

    vid_ctl_t [DATA_LAT:0] dly_q, dly_d;

    logic [7:0] vga_r_q, vga_r_d;
    logic [7:0] vga_g_q, vga_g_d;
    logic [7:0] vga_b_q, vga_b_d;
    vid_ctl_t   out_ctl_q, out_ctl_d;

    // ------------------------------------------------------------------
    // Counter next state: h wraps after H_LAST, v advances only on h wrap
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        h_wrap  = (h_cnt_q == H_LAST);

        if (h_wrap) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + 10'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state always uses non-blocking assignment so
        // every register samples the pre-edge values of its sources.
        if (i_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Decode of the current position and next request-stage contents
    // ------------------------------------------------------------------
    always_comb begin
        cur_ctl      = CTL_IDLE;
        cur_ctl.act  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        cur_ctl.hs_n = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
        // vsync spans whole lines, so it depends on v_cnt alone
        cur_ctl.vs_n = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));

        // Position is forced to zero outside the active area so upstream
        // never sees stale coordinates while req is low.
        req_d         = cur_ctl.act;
        req_x_d       = cur_ctl.act ? h_cnt_q : '0;
        req_y_d       = cur_ctl.act ? v_cnt_q : '0;
        line_start_d  = cur_ctl.act && (h_cnt_q == '0);
        frame_start_d = cur_ctl.act && (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Request stage registers, one cycle behind the counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_q         <= 1'b0;
            req_x_q       <= '0;
            req_y_q       <= '0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            req_q         <= req_d;
            req_x_q       <= req_x_d;
            req_y_q       <= req_y_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    assign pix_if.req         = req_q;
    assign pix_if.req_x       = req_x_q;
    assign pix_if.req_y       = req_y_q;
    assign pix_if.frame_start = frame_start_q;
    assign pix_if.line_start  = line_start_q;

    // ------------------------------------------------------------------
    // Control delay line: stage 0 is parallel to the request stage, stage
    // DATA_LAT lines up with the cycle in which upstream data is present.
    // ------------------------------------------------------------------
    always_comb begin
        dly_d = {dly_q[DATA_LAT-1:0], cur_ctl};
    end

    // Delay line registers
    always_ff @(posedge i_clk) begin
        // NOTE: this storage is reset stage by stage on purpose; a stale
        // active bit surviving reset would let upstream data reach the
        // pins during the first cycles after release.
        if (i_rst) begin
            dly_q <= {(DATA_LAT + 1){CTL_IDLE}};
        end else begin
            dly_q <= dly_d;
        end
    end

    // ------------------------------------------------------------------
    // Output stage: RGB is taken from upstream only for active positions
    // and forced to black elsewhere, whatever upstream drives then.
    // ------------------------------------------------------------------
    always_comb begin
        out_ctl_d = dly_q[DATA_LAT];
        vga_r_d   = '0;
        vga_g_d   = '0;
        vga_b_d   = '0;
        if (dly_q[DATA_LAT].act) begin
            vga_r_d = pix_if.r;
            vga_g_d = pix_if.g;
            vga_b_d = pix_if.b;
        end
    end

    // Pin registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vga_r_q   <= '0;
            vga_g_q   <= '0;
            vga_b_q   <= '0;
            out_ctl_q <= CTL_IDLE;
        end else begin
            vga_r_q   <= vga_r_d;
            vga_g_q   <= vga_g_d;
            vga_b_q   <= vga_b_d;
            out_ctl_q <= out_ctl_d;
        end
    end

    assign o_vga_r   = vga_r_q;
    assign o_vga_g   = vga_g_q;
    assign o_vga_b   = vga_b_q;
    assign o_h_sync  = out_ctl_q.hs_n;
    assign o_v_sync  = out_ctl_q.vs_n;
    assign o_blank_n = out_ctl_q.act;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen. Two instances with reduced
// screen geometry run side by side, one with DATA_LAT=1 and one with
// DATA_LAT=3. A reference model derives, from the per-cycle reset history
// alone, the screen position each cycle holds (cycle count since release
// modulo line and frame length) and from that every expected output.
module tb_vga_timing_gen;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 6;
    localparam int H_BP     = 5;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 31
    localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 13
    localparam int FRAME    = H_TOT * V_TOT;                    // 403
    localparam int MAXC     = 16384;
    localparam int C0       = 5;  // first cycle with reset released

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if pix1 ();
    vga_timing_gen_if pix3 ();

    logic [7:0] r1, g1, b1, r3, g3, b3;
    logic       hs1, vs1, bn1, hs3, vs3, bn3;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .DATA_LAT(1)
    ) u_dut1 (
        .i_clk(clk), .i_rst(rst), .pix_if(pix1.master),
        .o_vga_r(r1), .o_vga_g(g1), .o_vga_b(b1),
        .o_h_sync(hs1), .o_v_sync(vs1), .o_blank_n(bn1)
    );

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .DATA_LAT(3)
    ) u_dut3 (
        .i_clk(clk), .i_rst(rst), .pix_if(pix3.master),
        .o_vga_r(r3), .o_vga_g(g3), .o_vga_b(b3),
        .o_h_sync(hs3), .o_v_sync(vs3), .o_blank_n(bn3)
    );

    // Bookkeeping
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = -1;
    int mode     = 1;  // 0: random image, 1: constant AA/55/FF, 2: all 0xFF

    bit         rst_h  [MAXC];
    int         k_h    [MAXC];  // cycles since release, -1 while in reset
    int         mode_h [MAXC];
    bit         obs_v  [2][MAXC];
    logic [9:0] obs_x  [2][MAXC];
    logic [9:0] obs_y  [2][MAXC];

    logic [7:0] tbl_r [V_ACTIVE][H_ACTIVE];
    logic [7:0] tbl_g [V_ACTIVE][H_ACTIVE];
    logic [7:0] tbl_b [V_ACTIVE][H_ACTIVE];

    // Aggregate timing measurements over the first two clean frames
    int req_cnt = 0, req_run = 0, req_run_max = 0;
    int ls_cnt = 0, fs_cnt = 0, fs_t0 = -1, fs_t1 = -1;
    int hs_low1 = 0, vs_low1 = 0, hs_run = 0, hs_run_max = 0;
    int first_bn1 = -1, first_hs1 = -1, first_hs3 = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit rst_at(input int t);
        return (t < 0) ? 1'b1 : rst_h[t];
    endfunction

    function automatic int h_of(input int k);
        return k % H_TOT;
    endfunction

    function automatic int v_of(input int k);
        return (k / H_TOT) % V_TOT;
    endfunction

    // Image upstream serves; the DATA_LAT=3 instance gets the column on red
    function automatic logic [23:0] pix_of(input int lat, input int md, input int x, input int y);
        if (md == 1) return 24'hAA55FF;
        if (md == 2) return 24'hFFFFFF;
        if (x >= H_ACTIVE || y >= V_ACTIVE) return 24'h0;
        return {(lat == 3) ? 8'(x) : tbl_r[y][x], tbl_g[y][x], tbl_b[y][x]};
    endfunction

    function automatic logic [23:0] idle_data(input int md);
        if (md == 1) return 24'hAA55FF;
        if (md == 2) return 24'hFFFFFF;
        return 24'($urandom);
    endfunction

    task automatic check_dut(input int lat,
                             input logic req, input logic [9:0] rx, input logic [9:0] ry,
                             input logic fs, input logic ls,
                             input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input logic hs, input logic vs, input logic bn);
        int          t;
        int          h;
        int          v;
        int          s;
        bit          e_req;
        bit          ok;
        bit          a;
        bit          ehs;
        bit          evs;
        logic [23:0] e_rgb;
        string       p;
        t     = cyc;
        p     = $sformatf("d%0d.", lat);
        e_req = 1'b0;
        h     = 0;
        v     = 0;
        if (!rst_at(t - 1)) begin
            h     = h_of(k_h[t-1]);
            v     = v_of(k_h[t-1]);
            e_req = (h < H_ACTIVE) && (v < V_ACTIVE);
        end
        check({p, "req"},         32'(req), 32'(e_req));
        check({p, "req_x"},       32'(rx),  e_req ? 32'(h) : 32'd0);
        check({p, "req_y"},       32'(ry),  e_req ? 32'(v) : 32'd0);
        check({p, "frame_start"}, 32'(fs),  32'(e_req && h == 0 && v == 0));
        check({p, "line_start"},  32'(ls),  32'(e_req && h == 0));

        s  = t - 2 - lat;
        ok = (s >= 0);
        for (int i = s; i < t; i++) if (rst_at(i)) ok = 1'b0;
        a     = 1'b0;
        ehs   = 1'b1;
        evs   = 1'b1;
        e_rgb = 24'h0;
        if (ok) begin
            h   = h_of(k_h[s]);
            v   = v_of(k_h[s]);
            a   = (h < H_ACTIVE) && (v < V_ACTIVE);
            ehs = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
            evs = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
            if (a) e_rgb = pix_of(lat, mode_h[t-1], h, v);
        end
        check({p, "blank_n"}, 32'(bn), 32'(a));
        check({p, "h_sync"},  32'(hs), 32'(ehs));
        check({p, "v_sync"},  32'(vs), 32'(evs));
        check({p, "vga_r"},   32'(r),  32'(e_rgb[23:16]));
        check({p, "vga_g"},   32'(g),  32'(e_rgb[15:8]));
        check({p, "vga_b"},   32'(b),  32'(e_rgb[7:0]));
    endtask

    // Upstream: answer each observed request exactly lat cycles later
    task automatic drive(input int di, input int lat);
        int          src;
        logic [23:0] d;
        src = cyc - lat;
        if (src >= 0 && obs_v[di][src])
            d = pix_of(lat, mode, int'(obs_x[di][src]), int'(obs_y[di][src]));
        else
            d = idle_data(mode);
        if (di == 0) {pix1.r, pix1.g, pix1.b} = d;
        else         {pix3.r, pix3.g, pix3.b} = d;
    endtask

    task automatic measure();
        if (cyc >= C0 + 1 && cyc < C0 + 1 + 2 * FRAME) begin
            if (pix1.req) req_cnt++;
            req_run     = pix1.req ? req_run + 1 : 0;
            req_run_max = (req_run > req_run_max) ? req_run : req_run_max;
            if (pix1.line_start) ls_cnt++;
            if (pix1.frame_start) begin
                if (fs_cnt == 0) fs_t0 = cyc;
                if (fs_cnt == 1) fs_t1 = cyc;
                fs_cnt++;
            end
        end
        if (cyc >= C0 + 3 && cyc < C0 + 3 + 2 * FRAME) begin
            if (!hs1) hs_low1++;
            if (!vs1) vs_low1++;
            hs_run     = !hs1 ? hs_run + 1 : 0;
            hs_run_max = (hs_run > hs_run_max) ? hs_run : hs_run_max;
            if (bn1 && first_bn1 < 0) first_bn1 = cyc;
            if (!hs1 && first_hs1 < 0) first_hs1 = cyc;
        end
        if (cyc >= C0 + 5 && cyc < C0 + 5 + 2 * FRAME) begin
            if (!hs3 && first_hs3 < 0) first_hs3 = cyc;
        end
    endtask

    // One clock cycle: sample outputs #1 after the edge, then drive inputs
    task automatic step(input bit rst_v);
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d cycles, expected fewer than %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        rst_h[cyc]  = rst_v;
        mode_h[cyc] = mode;
        k_h[cyc]    = rst_v ? -1 : ((cyc > 0 && k_h[cyc-1] >= 0) ? k_h[cyc-1] + 1 : 0);
        rst         = rst_v;

        check_dut(1, pix1.req, pix1.req_x, pix1.req_y, pix1.frame_start, pix1.line_start,
                  r1, g1, b1, hs1, vs1, bn1);
        check_dut(3, pix3.req, pix3.req_x, pix3.req_y, pix3.frame_start, pix3.line_start,
                  r3, g3, b3, hs3, vs3, bn3);

        obs_v[0][cyc] = pix1.req;
        obs_x[0][cyc] = pix1.req_x;
        obs_y[0][cyc] = pix1.req_y;
        obs_v[1][cyc] = pix3.req;
        obs_x[1][cyc] = pix3.req_x;
        obs_y[1][cyc] = pix3.req_y;
        drive(0, 1);
        drive(1, 3);
        measure();
    endtask

    initial begin
        for (int y = 0; y < V_ACTIVE; y++) begin
            for (int x = 0; x < H_ACTIVE; x++) begin
                tbl_r[y][x] = 8'($urandom);
                tbl_g[y][x] = 8'($urandom);
                tbl_b[y][x] = 8'($urandom);
            end
        end
        {pix1.r, pix1.g, pix1.b} = 24'hAA55FF;
        {pix3.r, pix3.g, pix3.b} = 24'hAA55FF;

        // Power-up reset, then two clean frames with constant AA/55/FF
        mode = 1;
        repeat (C0) step(1'b1);
        repeat (2 * FRAME + 20) step(1'b0);

        check("fs_count",    32'(fs_cnt),      32'd2);
        check("fs_period",   32'(fs_t1 - fs_t0), 32'(FRAME));
        check("ls_count",    32'(ls_cnt),      32'(2 * V_ACTIVE));
        check("req_count",   32'(req_cnt),     32'(2 * V_ACTIVE * H_ACTIVE));
        check("req_run",     32'(req_run_max), 32'(H_ACTIVE));
        check("hs_low",      32'(hs_low1),     32'(2 * V_TOT * H_SYNC));
        check("hs_run",      32'(hs_run_max),  32'(H_SYNC));
        check("vs_low",      32'(vs_low1),     32'(2 * V_SYNC * H_TOT));
        check("hs_offset",   32'(first_hs1 - first_bn1), 32'(H_ACTIVE + H_FP));
        check("hs_shift_l3", 32'(first_hs3 - first_hs1), 32'd2);

        // Mid-frame reset hold, then random run lengths and reset pulses
        mode = 0;
        repeat (5) step(1'b1);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(40, 700)) step(1'b0);
            repeat ($urandom_range(1, 4)) step(1'b1);
        end

        // Upstream drives 0xFF continuously: blanking must mask it
        mode = 2;
        repeat (FRAME + 40) step(1'b0);

        mode = 0;
        repeat (100) step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
